// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI slave endpoint, fully synchronous to clk. The sclk, cs_n and mosi pins
//   are oversampled through two-flop synchronisers, plus a third flop for
//   edge detection. Received words are deserialised MSB-first from mosi, and
//   transmit words are serialised MSB-first onto miso. Several words may be
//   sent back-to-back while cs_n stays low.
//
// Parameters
//   DATA_WIDTH : serial word length (>= 2)
//   CPOL       : idle level of sclk
//   CPHA       : 0 = sample on leading edge, shift on trailing edge
//                1 = shift on leading edge, sample on trailing edge
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   sclk       in   SPI clock from master (asynchronous)
//   cs_n       in   slave select, active low (asynchronous)
//   mosi       in   serial data from master (asynchronous)
//   miso       out  serial data to master
//   miso_oe    out  miso pad drive enable, high while a frame is active
//   tx_data    in   next word to send, captured when tx_load pulses
//   tx_load    out  one-cycle pulse: tx_data captured this cycle
//   rx_data    out  last complete received word
//   rx_valid   out  one-cycle pulse: rx_data updated this cycle
//   busy       out  high while the frame is active
//   frame_err  out  one-cycle pulse: cs_n released in the middle of a word
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | cs_n high: miso parked low and undriven, sclk edges ignored
// ACTIVE  | cs_n low: sample/shift on sclk edges, count bits within a word
// ---------------------------------------------------------------------------
module spi_slave #(
   parameter int   DATA_WIDTH = 8,
   parameter logic CPOL       = 1'b0,
   parameter logic CPHA       = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_load,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int              CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Synchroniser chains: bit 0 = stage 1, bit 1 = stage 2, bit 2 = edge-detect stage.
   logic [2:0]            sclk_sync_q, sclk_sync_d;
   logic [2:0]            cs_sync_q,   cs_sync_d;
   logic [1:0]            mosi_sync_q, mosi_sync_d;

   state_t                state_q,     state_d;
   logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
   logic [DATA_WIDTH-1:0] tx_reg_q,    tx_reg_d;
   logic [DATA_WIDTH-1:0] rx_reg_q,    rx_reg_d;
   logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
   logic                  rx_valid_q,  rx_valid_d;
   logic                  tx_load_q,   tx_load_d;
   logic                  frame_err_q, frame_err_d;
   logic                  busy_q,      busy_d;
   logic                  miso_q,      miso_d;
   logic                  miso_oe_q,   miso_oe_d;

   logic                  sclk_toggle;
   logic                  sclk_lead;
   logic                  sclk_trail;
   logic                  sample_edge;
   logic                  shift_edge;
   logic                  cs_fall;
   logic                  cs_rise;
   logic [DATA_WIDTH-1:0] rx_shifted;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], sclk};
      cs_sync_d   = {cs_sync_q[1:0],   cs_n};
      mosi_sync_d = {mosi_sync_q[0],   mosi};
   end

   // Edge detection compares stage 2 against stage 3; the mosi bit is taken
   // from stage 2 so it lines up with the detected sclk edge.
   always_comb begin
      sclk_toggle = sclk_sync_q[1] ^ sclk_sync_q[2];
      sclk_lead   = sclk_toggle & (sclk_sync_q[2] == CPOL);
      sclk_trail  = sclk_toggle & (sclk_sync_q[1] == CPOL);
      sample_edge = CPHA ? sclk_trail : sclk_lead;
      shift_edge  = CPHA ? sclk_lead  : sclk_trail;
      cs_fall     =  cs_sync_q[2] & ~cs_sync_q[1];
      cs_rise     = ~cs_sync_q[2] &  cs_sync_q[1];
      rx_shifted  = {rx_reg_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      tx_reg_d    = tx_reg_q;
      rx_reg_d    = rx_reg_q;
      rx_data_d   = rx_data_q;
      busy_d      = busy_q;
      rx_valid_d  = 1'b0;
      tx_load_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_ACTIVE;
               tx_reg_d  = tx_data;
               tx_load_d = 1'b1;
               bit_cnt_d = '0;
               rx_reg_d  = '0;
               busy_d    = 1'b1;
            end
         end
         ST_ACTIVE: begin
            // cs_n release has priority over an sclk edge seen in the same cycle.
            if (cs_rise) begin
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               bit_cnt_d   = '0;
               rx_reg_d    = '0;
               tx_reg_d    = '0;
               frame_err_d = (bit_cnt_q != '0);
            end else if (sample_edge) begin
               rx_reg_d = rx_shifted;
               if (bit_cnt_q == CNT_LAST) begin
                  rx_data_d  = rx_shifted;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (shift_edge) begin
               // A zero count here means a fresh word starts on this shift:
               // the boundary between words (CPHA=0) or the first bit (CPHA=1).
               if (bit_cnt_q == '0) begin
                  tx_reg_d  = tx_data;
                  tx_load_d = 1'b1;
               end else begin
                  tx_reg_d = {tx_reg_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      miso_oe_d = (state_d == ST_ACTIVE);
      miso_d    = (state_d == ST_ACTIVE) ? tx_reg_d[DATA_WIDTH-1] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= {3{CPOL}};
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 2'b00;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         tx_reg_q    <= '0;
         rx_reg_q    <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_load_q   <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_reg_q    <= tx_reg_d;
         rx_reg_q    <= rx_reg_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_load_q   <= tx_load_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
      end
   end

   assign miso      = miso_q;
   assign miso_oe   = miso_oe_q;
   assign tx_load   = tx_load_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule
